// File: rtl/fifo_sync_param.sv
// Single-clock FIFO, DEPTH = 2**ADDR_W, with registered read port, occupancy
// count, programmable almost-full/almost-empty flags and overflow/underflow pulses.
module fifo_sync_param #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_in,
  input  logic [ADDR_W-1:0] full_umbral,
  input  logic [ADDR_W-1:0] empty_umbral,
  output logic [DATA_W-1:0] fifo_out,
  output logic              fifo_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  always_comb begin
    full         = (fifo_count == DEPTH_CNT);
    empty        = (fifo_count == '0);
    almost_full  = (full_umbral != '0) && (fifo_count >= {1'b0, full_umbral});
    almost_empty = (fifo_count <= {1'b0, empty_umbral});
    // A push into a full FIFO is still accepted when a pop frees the slot on the same edge.
    push_ok      = fifo_wr && (!full || fifo_rd);
    pop_ok       = fifo_rd && !empty;
  end

  always_ff @(posedge clk) begin
    if (reset && push_ok) begin
      mem[wr_ptr] <= fifo_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_out   <= '0;
      fifo_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      overflow   <= fifo_wr && full && !fifo_rd;
      underflow  <= fifo_rd && empty;
      fifo_valid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        fifo_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param: pops queue their expected word, a
// monitor compares fifo_out whenever fifo_valid is seen.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_wr = 1'b0;
  logic        fifo_rd = 1'b0;
  logic [11:0] fifo_in = '0;
  logic [2:0]  full_umbral = 3'd6;
  logic [2:0]  empty_umbral = 3'd1;
  logic [11:0] fifo_out;
  logic        fifo_valid;
  logic [3:0]  fifo_count;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [11:0] exp_q[$];

  fifo_sync_param #(.DATA_W(12), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_in(fifo_in), .full_umbral(full_umbral), .empty_umbral(empty_umbral),
    .fifo_out(fifo_out), .fifo_valid(fifo_valid), .fifo_count(fifo_count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock edge with the given request; returns at the following falling edge.
  task automatic step(input logic wr, input logic rd, input logic [11:0] d);
    fifo_wr = wr;
    fifo_rd = rd;
    fifo_in = d;
    @(posedge clk);
    @(negedge clk);
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
  endtask

  task automatic pop_expect(input logic [11:0] d);
    exp_q.push_back(d);
    step(1'b0, 1'b1, 12'h000);
    chk("pop_valid", {31'd0, fifo_valid}, 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (fifo_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {20'd0, fifo_out}, 32'hFFFF_FFFF);
        end else begin
          chk("pop_data", {20'd0, fifo_out}, {20'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] words [4];
    words[0] = 12'h123; words[1] = 12'hABC; words[2] = 12'h456; words[3] = 12'hDEF;

    // 1: reset state with clock running
    repeat (3) @(negedge clk);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_aempty", {31'd0, almost_empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_out", {20'd0, fifo_out}, 32'd0);
    chk("rst_valid", {31'd0, fifo_valid}, 32'd0);
    chk("rst_ovf_udf", {30'd0, overflow, underflow}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 2: four pushes, four pops
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, words[i]);
      chk("t2_push_count", {28'd0, fifo_count}, i + 1);
      chk("t2_aempty", {31'd0, almost_empty}, (i == 0) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_expect(words[i]);
      chk("t2_pop_count", {28'd0, fifo_count}, 3 - i);
    end
    chk("t2_aempty_end", {31'd0, almost_empty}, 32'd1);
    step(1'b0, 1'b0, 12'h000);
    chk("t2_valid_drop", {31'd0, fifo_valid}, 32'd0);

    // 3: fill past full
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 12'(i));
      chk("t3_count", {28'd0, fifo_count}, i);
      chk("t3_afull", {31'd0, almost_full}, (i >= 6) ? 32'd1 : 32'd0);
      chk("t3_full", {31'd0, full}, (i == 8) ? 32'd1 : 32'd0);
      chk("t3_ovf_low", {31'd0, overflow}, 32'd0);
    end
    step(1'b1, 1'b0, 12'h009);
    chk("t3_ovf_pulse", {31'd0, overflow}, 32'd1);
    chk("t3_count_held", {28'd0, fifo_count}, 32'd8);
    step(1'b0, 1'b0, 12'h000);
    chk("t3_ovf_clear", {31'd0, overflow}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      pop_expect(12'(i));
      chk("t3_drain_count", {28'd0, fifo_count}, 8 - i);
    end

    // 4: pop while empty
    step(1'b0, 1'b1, 12'h000);
    chk("t4_udf", {31'd0, underflow}, 32'd1);
    chk("t4_valid", {31'd0, fifo_valid}, 32'd0);
    chk("t4_out_held", {20'd0, fifo_out}, 32'h008);
    chk("t4_count", {28'd0, fifo_count}, 32'd0);
    step(1'b0, 1'b0, 12'h000);
    chk("t4_udf_clear", {31'd0, underflow}, 32'd0);

    // 5: simultaneous push/pop at full and at empty
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'h010 + 12'(i));
    exp_q.push_back(12'h010);
    step(1'b1, 1'b1, 12'h0AA);
    chk("t5_full_count", {28'd0, fifo_count}, 32'd8);
    chk("t5_full_ovf", {31'd0, overflow}, 32'd0);
    chk("t5_full_valid", {31'd0, fifo_valid}, 32'd1);
    for (int i = 1; i < 8; i++) pop_expect(12'h010 + 12'(i));
    pop_expect(12'h0AA);
    chk("t5_drained", {28'd0, fifo_count}, 32'd0);
    step(1'b1, 1'b1, 12'h055);
    chk("t5_empty_count", {28'd0, fifo_count}, 32'd1);
    chk("t5_empty_udf", {31'd0, underflow}, 32'd1);
    chk("t5_empty_valid", {31'd0, fifo_valid}, 32'd0);
    pop_expect(12'h055);

    // 6: asynchronous reset mid-operation, disabled almost_full
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'h100 + 12'(i));
    chk("t6_pre_count", {28'd0, fifo_count}, 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_count", {28'd0, fifo_count}, 32'd0);
    chk("t6_async_empty", {31'd0, empty}, 32'd1);
    full_umbral = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b1, 12'h000);
    chk("t6_udf", {31'd0, underflow}, 32'd1);
    chk("t6_valid", {31'd0, fifo_valid}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'h200 + 12'(i));
    chk("t6_full", {31'd0, full}, 32'd1);
    chk("t6_afull_disabled", {31'd0, almost_full}, 32'd0);
    full_umbral = 3'd6;
    #1;
    chk("t6_afull_live", {31'd0, almost_full}, 32'd1);
    for (int i = 0; i < 8; i++) pop_expect(12'h200 + 12'(i));

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
